// File: rtl/tile_collision_responder.sv
// tile_collision_responder: services collision-FSM tile lookups and pill-eat write-backs on tile RAM
//
// Optional feature macro: POWER_PILL_EN
//   defined     -> POWER_CODE reports is_power=1, is_pill=0
//   not defined -> is_power tied 0, POWER_CODE reports is_pill=1
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   req, req_addr          lookup strobe and absolute CPU tile address (sampled when busy=0)
//   eat                    consume the last pill looked up (sampled when busy=0)
//   cpu_paused             tile RAM is free for this block
//   busy                   FSM not idle
//   rsp_valid, rsp_tile    one-cycle response pulse and tile code (0 on address error)
//   is_wall/is_pill/is_power, addr_err   classification, held until the next response
//   ram_addr, ram_rd_en, ram_we, ram_wdata, ram_rdata   synchronous tile RAM port
//   pill_count             pills eaten since reset, saturating at 255
module tile_collision_responder #(
    parameter logic [7:0]  WALL_LO    = 8'hC0,
    parameter logic [7:0]  PILL_CODE  = 8'h10,
    parameter logic [7:0]  POWER_CODE = 8'h14,
    parameter logic [7:0]  BLANK_CODE = 8'h40,
    parameter logic [15:0] TILE_BASE  = 16'h4000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [15:0] req_addr,
    input  logic        eat,
    input  logic        cpu_paused,
    output logic        busy,
    output logic        rsp_valid,
    output logic [7:0]  rsp_tile,
    output logic        is_wall,
    output logic        is_pill,
    output logic        is_power,
    output logic        addr_err,
    output logic [9:0]  ram_addr,
    output logic        ram_rd_en,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic [7:0]  pill_count
);
    typedef enum logic [2:0] {IDLE, GRANT_WAIT, READ, RESP, EAT_WR} state_t;
    state_t     r_state;
    logic [9:0] r_addr;
    logic [9:0] r_pill_addr;
    logic       r_pill_valid;
    logic       r_eat_pend;
    logic       w_in_win;
    logic       w_is_pill;
    logic       w_is_power;
    assign w_in_win = req_addr[15:10] == TILE_BASE[15:10];
`ifdef POWER_PILL_EN
    assign w_is_pill  = ram_rdata == PILL_CODE;
    assign w_is_power = ram_rdata == POWER_CODE;
`else
    assign w_is_pill  = ram_rdata == PILL_CODE || ram_rdata == POWER_CODE;
    assign w_is_power = 1'b0;
`endif
    // RAM strobes decode straight from the state register so an async reset drops them at once
    assign busy      = r_state != IDLE;
    assign ram_rd_en = r_state == READ;
    assign ram_we    = r_state == EAT_WR;
    assign ram_addr  = ram_we ? r_pill_addr : r_addr;
    assign ram_wdata = ram_we ? BLANK_CODE : 8'h00;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_pill_addr  <= '0;
            r_pill_valid <= 1'b0;
            r_eat_pend   <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_tile     <= '0;
            is_wall      <= 1'b0;
            is_pill      <= 1'b0;
            is_power     <= 1'b0;
            addr_err     <= 1'b0;
            pill_count   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    // an eat with no remembered pill is dropped and does not block a lookup
                    if (eat && r_pill_valid) begin
                        r_eat_pend <= 1'b1;
                        r_state    <= cpu_paused ? EAT_WR : GRANT_WAIT;
                    end else if (req) begin
                        r_addr <= req_addr[9:0];
                        if (!w_in_win) begin
                            rsp_valid <= 1'b1;
                            addr_err  <= 1'b1;
                            rsp_tile  <= '0;
                            is_wall   <= 1'b0;
                            is_pill   <= 1'b0;
                            is_power  <= 1'b0;
                        end else begin
                            r_eat_pend <= 1'b0;
                            r_state    <= cpu_paused ? READ : GRANT_WAIT;
                        end
                    end
                end
                GRANT_WAIT: if (cpu_paused) r_state <= r_eat_pend ? EAT_WR : READ;
                READ: r_state <= RESP;
                RESP: begin
                    rsp_valid    <= 1'b1;
                    rsp_tile     <= ram_rdata;
                    addr_err     <= 1'b0;
                    is_wall      <= ram_rdata >= WALL_LO;
                    is_pill      <= w_is_pill;
                    is_power     <= w_is_power;
                    r_pill_valid <= w_is_pill | w_is_power;
                    r_pill_addr  <= r_addr;
                    r_state      <= IDLE;
                end
                EAT_WR: begin
                    pill_count   <= pill_count == 8'hFF ? pill_count : pill_count + 8'd1;
                    r_pill_valid <= 1'b0;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tile_collision_responder.sv
// tb_tile_collision_responder: table, directed and randomized checks of the tile collision responder
module tb_tile_collision_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [15:0] req_addr = '0;
    logic        eat = 1'b0;
    logic        cpu_paused = 1'b0;
    logic        busy, rsp_valid, is_wall, is_pill, is_power, addr_err, ram_rd_en, ram_we;
    logic [7:0]  rsp_tile, ram_wdata, ram_rdata, pill_count;
    logic [9:0]  ram_addr;
    logic [7:0]  mem [1024];
    logic        poke_en = 1'b0;
    logic [9:0]  poke_a = '0;
    logic [7:0]  poke_d = '0;
    logic [7:0]  ref_mem [1024];
    logic        lp_valid;
    logic [9:0]  lp_addr;
    int          cnt_m;
    int          checks = 0;
    int          failures = 0;
    int          overlap = 0;

    tile_collision_responder dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .eat(eat), .cpu_paused(cpu_paused),
        .busy(busy), .rsp_valid(rsp_valid), .rsp_tile(rsp_tile), .is_wall(is_wall), .is_pill(is_pill),
        .is_power(is_power), .addr_err(addr_err), .ram_addr(ram_addr), .ram_rd_en(ram_rd_en),
        .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .pill_count(pill_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_rd_en) ram_rdata <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (poke_en) mem[poke_a] <= poke_d;
    end

    always @(negedge clk) if (ram_rd_en && ram_we) overlap++;

    typedef struct {
        logic [7:0] data;
        logic [2:0] exp;
    } vec_t;
    vec_t tbl [10];
`ifdef POWER_PILL_EN
    localparam logic [2:0] PWR_EXP = 3'b001;
`else
    localparam logic [2:0] PWR_EXP = 3'b010;
`endif

    // {wall, pill, power} straight from the classification rules
    function automatic logic [2:0] cls(input logic [7:0] t);
`ifdef POWER_PILL_EN
        return {t >= 8'hC0, t == 8'h10, t == 8'h14};
`else
        return {t >= 8'hC0, t == 8'h10 || t == 8'h14, 1'b0};
`endif
    endfunction

    task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", n, got, exp);
        end
    endtask

    task automatic poke(input logic [9:0] a, input logic [7:0] d);
        @(negedge clk);
        poke_en = 1'b1;
        poke_a = a;
        poke_d = d;
        ref_mem[a] = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // cpu_paused stays low for d cycles after the request edge, then rises
    task automatic do_lookup(input logic [15:0] a, input int d, output int lat, output int rd_cnt,
                             output int early_rd, output logic [9:0] rd_a, output logic busy1);
        lat = 99; rd_cnt = 0; early_rd = 0; rd_a = '0; busy1 = 1'b0;
        @(negedge clk);
        req = 1'b1; req_addr = a; eat = 1'b0; cpu_paused = (d == 0);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            req = 1'b0;
            if (k == 1) busy1 = busy;
            if (ram_rd_en) begin
                rd_cnt++;
                rd_a = ram_addr;
                if (k <= d) early_rd++;
            end
            if (rsp_valid) begin
                lat = k;
                break;
            end
            cpu_paused = (k >= d);
        end
    endtask

    task automatic lookup_check(input logic [15:0] a, input int d);
        int lat, rd_cnt, early_rd;
        logic [9:0] rd_a;
        logic busy1, in_win;
        logic [7:0] t;
        in_win = a[15:10] == 6'h10;
        t = in_win ? ref_mem[a[9:0]] : 8'h00;
        do_lookup(a, d, lat, rd_cnt, early_rd, rd_a, busy1);
        check("lookup_latency", lat, in_win ? d + 3 : 1);
        check("lookup_rd_count", rd_cnt, {31'd0, in_win});
        check("lookup_rd_before_grant", early_rd, 0);
        if (in_win) check("lookup_rd_addr", {22'd0, rd_a}, {22'd0, a[9:0]});
        check("lookup_busy", {31'd0, busy1}, {31'd0, in_win});
        check("lookup_tile", {24'd0, rsp_tile}, {24'd0, t});
        check("lookup_flags", {29'd0, is_wall, is_pill, is_power}, in_win ? {29'd0, cls(t)} : 0);
        check("lookup_addr_err", {31'd0, addr_err}, {31'd0, !in_win});
        if (in_win) begin
            lp_valid = t == 8'h10 || t == 8'h14;
            lp_addr = a[9:0];
        end
    endtask

    task automatic eat_check(input int d);
        int we_cnt = 0, we_k = 0, both = 0;
        logic [9:0] we_a = '0;
        logic [7:0] we_d = '0;
        @(negedge clk);
        eat = 1'b1; req = 1'b0; cpu_paused = (d == 0);
        for (int k = 1; k <= d + 4; k++) begin
            @(negedge clk);
            eat = 1'b0;
            if (ram_we) begin
                we_cnt++;
                we_k = k;
                we_a = ram_addr;
                we_d = ram_wdata;
            end
            if (ram_we && ram_rd_en) both++;
            cpu_paused = (k >= d);
        end
        if (lp_valid) begin
            check("eat_we_count", we_cnt, 1);
            check("eat_we_cycle", we_k, d + 1);
            check("eat_we_addr", {22'd0, we_a}, {22'd0, lp_addr});
            check("eat_we_data", {24'd0, we_d}, 32'h40);
            ref_mem[lp_addr] = 8'h40;
            cnt_m = cnt_m == 255 ? 255 : cnt_m + 1;
            lp_valid = 1'b0;
        end else begin
            check("eat_ignored_we", we_cnt, 0);
        end
        check("eat_rd_we_overlap", both, 0);
        check("eat_pill_count", {24'd0, pill_count}, cnt_m);
        check("eat_busy_after", {31'd0, busy}, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        logic [7:0] pick [6];
        logic [15:0] a;
        int bad;
        pick[0] = 8'h10; pick[1] = 8'h14; pick[2] = 8'h40; pick[3] = 8'hC0; pick[4] = 8'hD5; pick[5] = 8'h00;
        tbl[0] = '{8'h14, PWR_EXP}; tbl[1] = '{8'h10, 3'b010}; tbl[2] = '{8'hD5, 3'b100};
        tbl[3] = '{8'hC0, 3'b100}; tbl[4] = '{8'hBF, 3'b000}; tbl[5] = '{8'h40, 3'b000};
        tbl[6] = '{8'hFF, 3'b100}; tbl[7] = '{8'h00, 3'b000}; tbl[8] = '{8'h11, 3'b000};
        tbl[9] = '{8'h13, 3'b000};
        lp_valid = 1'b0; lp_addr = '0; cnt_m = 0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            poke_en = 1'b1;
            poke_a = 10'(i);
            poke_d = $urandom_range(0, 5) == 5 ? 8'($urandom) : pick[$urandom_range(0, 4)];
            ref_mem[i] = poke_d;
        end
        @(negedge clk);
        poke_en = 1'b0;
        check("reset_outputs", {20'd0, busy, rsp_valid, rsp_tile, is_wall, is_pill, is_power, addr_err, ram_rd_en, ram_we}, 0);
        check("reset_ram_port", {14'd0, ram_addr, ram_wdata}, 0);
        check("reset_pill_count", {24'd0, pill_count}, 0);
        rst = 1'b0;
        poke(10'h123, 8'hD5);
        lookup_check(16'h4123, 0);
        poke(10'h050, 8'h10);
        lookup_check(16'h4050, 0);
        eat_check(0);
        eat_check(0);
        poke(10'h300, 8'h14);
        lookup_check(16'h4300, 4);
        eat_check(2);
        lookup_check(16'h5000, 0);
        for (int i = 0; i < 10; i++) begin
            poke(10'(16'h010 + i), tbl[i].data);
            lookup_check(16'(16'h4010 + i), i % 3);
            check("table_flags", {29'd0, is_wall, is_pill, is_power}, {29'd0, tbl[i].exp});
            check("table_tile", {24'd0, rsp_tile}, {24'd0, tbl[i].data});
        end
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 2) == 2) begin
                eat_check($urandom_range(0, 3));
            end else begin
                a = $urandom_range(0, 4) == 0 ? 16'($urandom) : {6'h10, 10'($urandom)};
                lookup_check(a, $urandom_range(0, 3));
            end
        end
        for (int i = 0; i < 256; i++) begin
            poke(10'h200, 8'h10);
            lookup_check(16'h4200, 0);
            eat_check(0);
        end
        check("pill_count_saturated", {24'd0, pill_count}, 255);
        poke(10'h077, 8'h10);
        lookup_check(16'h4077, 0);
        @(negedge clk);
        eat = 1'b1; cpu_paused = 1'b1;
        @(negedge clk);
        eat = 1'b0;
        check("eat_wr_before_reset", {31'd0, ram_we}, 1);
        #1 rst = 1'b1;
        #1;
        check("reset_mid_eat_we", {31'd0, ram_we}, 0);
        check("reset_mid_eat_busy", {31'd0, busy}, 0);
        check("reset_mid_eat_count", {24'd0, pill_count}, 0);
        @(negedge clk);
        rst = 1'b0;
        cnt_m = 0;
        lp_valid = 1'b0;
        eat_check(0);
        bad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("ram_contents", bad, 0);
        check("rd_we_never_together", overlap, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tile_collision_responder.md
Name: tile_collision_responder

Overview:
- Responder side of the sprite collision lookup. It services tile-RAM lookup requests issued by the collision FSM while the CPU is paused.
- Per request: reads the 8-bit tile code from tile RAM (0x4000–0x43FF), classifies it (wall / pill / power pill) and returns a registered response.
- On an eat command, writes the blank tile back over the last pill looked up and counts eaten pills.
- Sits between the collision FSM and the tile-RAM port of the video memory.

Parameters:
- WALL_LO, 8'hC0: tile codes >= WALL_LO are walls.
- PILL_CODE, 8'h10: tile code of a normal pill.
- POWER_CODE, 8'h14: tile code of a power pill (energizer).
- BLANK_CODE, 8'h40: code written back when a pill is eaten.
- TILE_BASE, 16'h4000: tile RAM base address; window is 1024 bytes.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  lookup request, single-cycle strobe, sampled only when busy=0.
- req_addr  in  16  absolute CPU address of the tile (TILEMAP offset already added).
- eat  in  1  consume-pill strobe, sampled only when busy=0.
- cpu_paused  in  1  CPU is halted; tile RAM is free for this block.
- busy  out  1  high whenever the FSM is not in IDLE.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_tile  out  8  tile code read (0 on address error).
- is_wall, is_pill, is_power  out  1 each  classification; held until the next response.
- addr_err  out  1  last request fell outside the tile window.
- ram_addr  out  10  tile RAM word address.
- ram_rd_en  out  1  read enable; synchronous RAM, data valid next cycle.
- ram_we  out  1  write enable.
- ram_wdata  out  8  write data.
- ram_rdata  in  8  read data.
- pill_count  out  8  pills eaten since reset; saturates at 255.

Behaviour:
- Reset: all outputs 0, state IDLE, last-pill-valid flag cleared, pill_count=0.
- Reset mid-operation aborts immediately; ram_we/ram_rd_en drop asynchronously.
- States: IDLE, GRANT_WAIT, READ, RESP, EAT_WR.

IDLE:
- eat has priority over req when both are high.
- eat=1 with last-pill-valid=0: ignored.
- eat=1 with last-pill-valid=1: go to EAT_WR if cpu_paused=1, else GRANT_WAIT with the eat pending.
- req=1: latch req_addr, then:
  - Address out of window (req_addr[15:10] != TILE_BASE[15:10]): no RAM access. Next cycle rsp_valid=1, addr_err=1, rsp_tile=0, flags=0. Stay IDLE.
  - In window, cpu_paused=1: go to READ.
  - In window, cpu_paused=0: go to GRANT_WAIT.

GRANT_WAIT:
- Hold until cpu_paused=1, then go to READ or EAT_WR per the pending op.
- New req/eat are ignored here.

READ:
- ram_rd_en=1, ram_addr=latched addr[9:0]. Go to RESP.

RESP:
- Capture ram_rdata. Go to IDLE.
- In the following cycle: rsp_valid=1, rsp_tile=data, addr_err=0, flags registered.
- Classification:
  - is_wall = (data >= WALL_LO).
  - is_pill = (data == PILL_CODE).
  - is_power per the optional feature.
- last-pill-valid := is_pill|is_power; remember the address.

EAT_WR:
- One cycle: ram_we=1, ram_addr=remembered addr, ram_wdata=BLANK_CODE.
- pill_count += 1, saturating at 255.
- Clear last-pill-valid. Go to IDLE. No rsp_valid.

Timing and signal rules:
- Latency: req at cycle 0 with cpu_paused=1 → READ in cycle 1, RESP in cycle 2, rsp_valid in cycle 3.
- Each cycle spent in GRANT_WAIT adds one cycle.
- busy is registered from the state: high in cycles 1–2 for an in-window lookup.
- ram_rd_en and ram_we are never asserted together.
- ram_rd_en and ram_we are never asserted while cpu_paused=0. If cpu_paused falls during READ or EAT_WR, the access still completes; the CPU is held by the collision FSM.

Optional Feature:
POWER_PILL_EN
- Defined: POWER_CODE sets is_power=1, is_pill=0.
- Not defined: is_power is tied 0 and POWER_CODE is classified as is_pill=1.
- Counting and eat behaviour are identical in both builds.

Test Plan:
- cpu_paused=1, req, req_addr=16'h4123, RAM[0x123]=8'hD5 → ram_rd_en with addr 0x123 in cycle 1; cycle 3 rsp_valid=1, rsp_tile=8'hD5, is_wall=1, is_pill=0.
- req_addr=16'h4050, RAM[0x050]=8'h10, then eat → rsp is_pill=1; EAT_WR writes 8'h40 to addr 0x050; pill_count=1. A second eat is ignored; pill_count stays 1.
- cpu_paused=0 at request, raised 4 cycles later → busy=1 throughout, no RAM access before the raise; rsp_valid 3 cycles after cpu_paused rises.
- req_addr=16'h5000 → next cycle rsp_valid=1, addr_err=1, rsp_tile=0, no ram_rd_en.
- RAM[0x010]=8'h14: with POWER_PILL_EN → is_power=1, is_pill=0; without it → is_pill=1, is_power=0.
- Assert rst during EAT_WR → ram_we drops immediately, pill_count=0, busy=0; 256 eats → pill_count saturates at 255.
